// File: rtl/round_controller_pkg.sv
// Shared game package: controller state encoding plus the round-delay LFSR
// seed, tap mask and next-value helper. The scorer imports the same package.
package round_controller_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StDelay,
      StLight,
      StResult,
      StHalt
   } game_state_e;

   localparam logic [15:0] LfsrSeed = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1, left-shifting form: taps on bits 15, 13, 12, 10
   localparam logic [15:0] LfsrTaps = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LfsrTaps)};
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   btn_i      raw asynchronous button
//   level_o    synchronized button level
//   rise_o     one-cycle pulse on a synchronized rising edge ("push")
module btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/round_controller.sv
// Reaction-game round controller: waits a pseudo-random delay, lights the round
// LED and adjudicates which player pushed first (or who jumped the light).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   btn_l/btn_r raw asynchronous player buttons
//   game_over   scorer reports a finished match; freezes play
//   leds_on     round light
//   winrnd      one-cycle adjudication pulse, qualified by right and tie
module round_controller
   import round_controller_pkg::*;
#(
   parameter logic [23:0] DLY_MIN     = 24'd5_000_000,
   parameter logic [23:0] DLY_MASK    = 24'h7F_FFFF,
   parameter logic [23:0] HOLD_CYCLES = 24'd2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_l,
   input  logic btn_r,
   input  logic game_over,
   output logic leds_on,
   output logic winrnd,
   output logic right,
   output logic tie
);

   game_state_e state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        leds_q, leds_d;
   logic        win_q, win_d;
   logic        right_q, right_d;
   logic        tie_q, tie_d;

   logic lvl_l, lvl_r, rise_l, rise_r;

   btn_sync u_sync_l (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_l),
      .level_o (lvl_l),
      .rise_o  (rise_l)
   );

   btn_sync u_sync_r (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_r),
      .level_o (lvl_r),
      .rise_o  (rise_r)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = 1'b0;
      right_d = 1'b0;
      tie_d   = 1'b0;
      lfsr_d  = lfsr_next(lfsr_q);

      unique case (state_q)
         StIdle: state_d = StArm;
         StArm: begin
            if (game_over) begin
               state_d = StHalt;
            end else if (!lvl_l && !lvl_r) begin
               cnt_d   = DLY_MIN + ({8'h0, lfsr_q} & DLY_MASK);
               state_d = StDelay;
            end
         end
         StDelay, StLight: begin
            // A push wins over the DELAY->LIGHT transition, so a push in the
            // cycle the counter hits zero still counts as jumping the light.
            if (rise_l || rise_r) begin
               win_d   = 1'b1;
               right_d = rise_r & ~rise_l;
               tie_d   = rise_l & rise_r;
               cnt_d   = HOLD_CYCLES;
               state_d = StResult;
            end else if (state_q == StDelay) begin
               if (cnt_q <= 24'd1) begin
                  cnt_d   = '0;
                  state_d = StLight;
               end else begin
                  cnt_d = cnt_q - 24'd1;
               end
            end
         end
         StResult: begin
            if (game_over) begin
               state_d = StHalt;
            end else if (cnt_q <= 24'd1) begin
               cnt_d   = '0;
               state_d = StArm;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase

      // During the winrnd cycle the light keeps the value it had at the push.
      leds_d = (state_d == StLight) | (win_d & leds_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         lfsr_q  <= LfsrSeed;
         leds_q  <= 1'b0;
         win_q   <= 1'b0;
         right_q <= 1'b0;
         tie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         leds_q  <= leds_d;
         win_q   <= win_d;
         right_q <= right_d;
         tie_q   <= tie_d;
      end
   end

   assign leds_on = leds_q;
   assign winrnd  = win_q;
   assign right   = right_q;
   assign tie     = tie_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: randomized rounds against a round-level model
// (LFSR-derived delay, push timing through the synchronizer) with a scoreboard
// of expected adjudications checked by an independent monitor.
module tb_round_controller;

   localparam int DMIN  = 4;
   localparam int DMASK = 3;
   localparam int HOLD  = 3;
   localparam int NEVER = 1 << 30;

   logic clk = 1'b0;
   logic rst, btn_l, btn_r, game_over;
   logic leds_on, winrnd, right, tie;

   always #5 clk = ~clk;

   round_controller #(
      .DLY_MIN     (24'(DMIN)),
      .DLY_MASK    (24'(DMASK)),
      .HOLD_CYCLES (24'(HOLD))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_l     (btn_l),
      .btn_r     (btn_r),
      .game_over (game_over),
      .leds_on   (leds_on),
      .winrnd    (winrnd),
      .right     (right),
      .tie       (tie)
   );

   // Cycle n = the interval after the n-th rising edge since reset release.
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      int cycle;
      bit e_right;
      bit e_tie;
      bit e_leds;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // LFSR value seen during cycle n: seed advanced once per cycle.
   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] v;
      v = 16'hACE1;
      repeat (n) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      return v;
   endfunction

   task automatic to_cycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic wait_check_leds(input int n, input int light_at);
      while (cyc < n) begin
         @(negedge clk);
         check("leds_on", leds_on, int'(cyc >= light_at));
      end
   endtask

   // Monitor: pops the scoreboard on every winrnd pulse.
   initial begin : monitor
      exp_t e;
      bit prev_win;
      prev_win = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_win = 1'b0;
         end else begin
            if (winrnd) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_winrnd: got winrnd=1 expected none (cycle %0d)", cyc);
               end else begin
                  e = sb.pop_front();
                  check("win_cycle", cyc, e.cycle);
                  check("win_right", right, e.e_right);
                  check("win_tie", tie, e.e_tie);
                  check("win_leds", leds_on, e.e_leds);
               end
            end else begin
               check("right_idle", right, 0);
               check("tie_idle", tie, 0);
            end
            if (prev_win) check("leds_after_win", leds_on, 0);
            prev_win = winrnd;
         end
      end
   end

   // kind: 0 light R, 1 light L, 2 light both, 3 jump L, 4 jump R, 5 jump both,
   //       6 push exactly as the delay expires (side from extra)
   task automatic play_round(input int a, input int kind, input int extra, input int hold,
                             input bit halt_after, output int next_a);
      int d, light_at, p, c, rel;
      bit bl, br;
      exp_t e;
      to_cycle(a);
      d        = DMIN + (int'(lfsr_at(a)) & DMASK);
      light_at = a + d + 1;
      if (kind <= 2)      p = light_at + extra;
      else if (kind <= 5) p = a + 2 + extra % (d - 1);
      else                p = a + d;
      bl = (kind inside {1, 2, 3, 5}) || (kind == 6 && extra % 2 == 0);
      br = (kind inside {0, 2, 4, 5}) || (kind == 6 && extra % 2 == 1);
      c  = p - 2;
      wait_check_leds(c, light_at);
      btn_l     = bl;
      btn_r     = br;
      e.cycle   = p + 1;
      e.e_right = br && !bl;
      e.e_tie   = bl && br;
      e.e_leds  = (p >= light_at);
      sb.push_back(e);
      rel = c + hold;
      to_cycle(rel);
      btn_l = 1'b0;
      btn_r = 1'b0;
      if (halt_after) begin
         to_cycle(p + 1);
         game_over = 1'b1;
         next_a    = -1;
      end else begin
         next_a = (p + 4 > rel + 2) ? p + 4 : rel + 2;
         to_cycle(p + 1);
         wait_check_leds(next_a, NEVER);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int a, d;
      rst       = 1'b1;
      btn_l     = 1'b0;
      btn_r     = 1'b0;
      game_over = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_leds", leds_on, 0);
      check("rst_winrnd", winrnd, 0);
      check("rst_right", right, 0);
      check("rst_tie", tie, 0);
      rst = 1'b0;

      a = 1;
      play_round(a, 0, 2, 1, 1'b0, a);  // right pushes in LIGHT
      play_round(a, 3, 1, 2, 1'b0, a);  // left jumps the light
      play_round(a, 2, 0, 1, 1'b0, a);  // tie in LIGHT
      play_round(a, 6, 0, 3, 1'b0, a);  // push as the delay expires
      play_round(a, 5, 2, 1, 1'b0, a);  // tie while jumping
      for (int i = 0; i < 10; i++) begin
         play_round(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, 3)), 1'b0, a);
      end
      play_round(a, 0, 1, 12, 1'b0, a); // btn_r held well past RESULT
      play_round(a, 4, 3, 1, 1'b0, a);

      // game_over during RESULT: frozen, pushes ignored, light stays off
      play_round(a, 0, 0, 1, 1'b1, a);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check("halt_leds", leds_on, 0);
         if (i == 3)  game_over = 1'b0;
         if (i == 5)  btn_r = 1'b1;
         if (i == 8)  btn_r = 1'b0;
         if (i == 12) begin btn_l = 1'b1; btn_r = 1'b1; end
         if (i == 14) begin btn_l = 1'b0; btn_r = 1'b0; end
      end

      // Reset leaves HALT; reset during the winrnd cycle drops outputs at once
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      a = 1;
      play_round(a, 0, 1, 1, 1'b1, a);
      game_over = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_async_leds", leds_on, 0);
      check("rst_async_winrnd", winrnd, 0);
      check("rst_async_right", right, 0);
      check("rst_async_tie", tie, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset mid-DELAY with a push pending: no winrnd may follow
      d = DMIN + (int'(lfsr_at(1)) & DMASK);
      to_cycle(1);
      btn_l = 1'b1;
      to_cycle(3);
      check("mid_delay_leds", leds_on, int'(3 >= d + 2));
      #1 rst = 1'b1;
      #1;
      check("mid_rst_leds", leds_on, 0);
      check("mid_rst_winrnd", winrnd, 0);
      btn_l = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      a = 1;
      play_round(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 2, 1'b0, a);
      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
